// File: rtl/temp_bcd_fmt_pkg.sv
// ----------------------------------------------------------------------------
// temp_pkg
// Shared types and constants for the temperature BCD formatter.
//   TX10_W     : width of the signed x10 temperature word (1/16 LSB)
//   MAG_W      : width of the rounded tenth-degree magnitude
//   NDIG       : number of BCD digits produced
//   RND_CONST  : rounding offset added before dropping the 1/16 scaling
//   RND_SHIFT  : number of fractional bits dropped
//   state_t    : formatter FSM states
//   bcd_t      : one BCD digit
// ----------------------------------------------------------------------------
package temp_pkg;

    localparam int TX10_W    = 18;
    localparam int MAG_W     = 14;
    localparam int NDIG      = 4;
    localparam int RND_CONST = 8;
    localparam int RND_SHIFT = 4;
    localparam int CNT_W     = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

endpackage : temp_pkg

// File: rtl/temp_bcd_fmt_if.sv
// ----------------------------------------------------------------------------
// temp_bcd_fmt_if
// Input and output handshake bundle of the temperature BCD formatter.
//   tx10      : signed temperature x10, LSB = 1/16 tenth-degree
//   in_valid  : tx10 valid
//   in_ready  : formatter idle, can accept
//   out_valid : result valid, held until accepted
//   out_ready : consumer accepts result
//   neg       : result negative
//   dig       : BCD digits {hundreds, tens, ones, tenths}
//   blank     : per-digit leading-zero blank mask, same order as dig
// Modports: master = producer/consumer side, slave = formatter side.
// ----------------------------------------------------------------------------
interface temp_bcd_fmt_if;
    import temp_pkg::*;

    logic [TX10_W-1:0] tx10;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              neg;
    logic [15:0]       dig;
    logic [3:0]        blank;

    modport master (
        output tx10, in_valid, out_ready,
        input  in_ready, out_valid, neg, dig, blank
    );

    modport slave (
        input  tx10, in_valid, out_ready,
        output in_ready, out_valid, neg, dig, blank
    );

endinterface : temp_bcd_fmt_if

// File: rtl/temp_bcd_fmt_dabble.sv
// ----------------------------------------------------------------------------
// bcd_dabble_step
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so that the following left shift carries into the next
// decimal position.
//   i_dig : BCD digit before correction
//   o_dig : corrected digit
// ----------------------------------------------------------------------------
module bcd_dabble_step
    import temp_pkg::*;
(
    input  bcd_t i_dig,
    output bcd_t o_dig
);

    assign o_dig = (i_dig >= bcd_t'(5)) ? i_dig + bcd_t'(3) : i_dig;

endmodule : bcd_dabble_step

// File: rtl/temp_bcd_fmt.sv
// ----------------------------------------------------------------------------
// temp_bcd_fmt
// Converts the signed x10 temperature word (1/16 LSB) into sign plus four BCD
// digits for the seven-segment driver. The 1/16 scaling is removed with
// round-half-away-from-zero, then an iterative double-dabble runs one bit per
// cycle. Latency from the accept edge to out_valid is 16 cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : temp_bcd_fmt_if.slave handshake bundle
// Build option: TBCD_LEADING_BLANK_EN enables leading-zero blanking of the
// hundreds and tens digits; otherwise blank is tied to zero.
// ----------------------------------------------------------------------------
module temp_bcd_fmt
    import temp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    temp_bcd_fmt_if.slave  bus
);

    state_t                r_state;
    state_t                w_next;
    logic [TX10_W-1:0]     r_tx10;
    logic [MAG_W-1:0]      r_mag;
    logic [4*NDIG-1:0]     r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg;
    logic [4*NDIG-1:0]     r_dig;
    logic [NDIG-1:0]       r_blank;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic [TX10_W:0]       w_ext;
    logic [TX10_W:0]       w_abs;
    logic [MAG_W-1:0]      w_mag;
    logic [4*NDIG-1:0]     w_bcd_adj;
    logic [NDIG-1:0]       w_blank;

    // The extra bit keeps |-131072| representable.
    assign w_ext = {r_tx10[TX10_W-1], r_tx10};
    assign w_abs = r_tx10[TX10_W-1] ? (~w_ext + (TX10_W+1)'(1)) : w_ext;
    assign w_mag = MAG_W'((w_abs + (TX10_W+1)'(RND_CONST)) >> RND_SHIFT);

    for (genvar g = 0; g < NDIG; g++) begin : g_step
        bcd_dabble_step u_step (
            .i_dig (r_bcd[4*g +: 4]),
            .o_dig (w_bcd_adj[4*g +: 4])
        );
    end

`ifdef TBCD_LEADING_BLANK_EN
    assign w_blank = {r_bcd[15:12] == 4'd0, r_bcd[15:8] == 8'd0, 2'b00};
`else
    assign w_blank = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = ABS;
            end
            ABS:   w_next = SHIFT;
            // One extra SHIFT cycle with r_cnt==0 latches the outputs.
            SHIFT: if (r_cnt == '0) w_next = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx10  <= '0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_dig   <= '0;
            r_blank <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) r_tx10 <= bus.tx10;
                ABS: begin
                    r_mag <= w_mag;
                    // Negative zero is shown as positive.
                    r_neg <= r_tx10[TX10_W-1] && (w_mag != '0);
                    r_bcd <= '0;
                    r_cnt <= CNT_W'(MAG_W);
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                        r_cnt          <= r_cnt - CNT_W'(1);
                    end else begin
                        r_dig   <= r_bcd;
                        r_blank <= w_blank;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.neg       = r_neg;
    assign bus.dig       = r_dig;
    assign bus.blank     = r_blank;

endmodule : temp_bcd_fmt

// File: tb/tb_temp_bcd_fmt.sv
// ----------------------------------------------------------------------------
// tb_temp_bcd_fmt
// Directed bench for temp_bcd_fmt with hand-computed expected digits.
// ----------------------------------------------------------------------------
module tb_temp_bcd_fmt;
    import temp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    temp_bcd_fmt_if bus ();

    temp_bcd_fmt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [15:0] d);
`ifdef TBCD_LEADING_BLANK_EN
        return {d[15:12] == 4'd0, d[15:8] == 8'd0, 2'b00};
`else
        return 4'b0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents v for exactly one edge; that edge is the accept edge N.
    task automatic start(input logic [TX10_W-1:0] v);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            step();
            w++;
        end
        check("start_ready", bus.in_ready, 1);
        bus.tx10     = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after N until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [TX10_W-1:0] v,
                           input logic [15:0] ed, input logic en);
        int lat;
        start(v);
        wait_out(lat);
        check({tag, "_lat"},   lat,       16);
        check({tag, "_dig"},   bus.dig,   ed);
        check({tag, "_neg"},   bus.neg,   en);
        check({tag, "_blank"}, bus.blank, exp_blank(ed));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, bus.out_valid, 0);
        check({tag, "_idle"},     bus.in_ready,  1);
    endtask

    initial begin
        int lat;
        bus.tx10      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_neg",       bus.neg,       0);
        check("rst_dig",       bus.dig,       0);
        check("rst_blank",     bus.blank,     0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready",  bus.in_ready,  1);

        // Main function and rounding boundaries
        run_vec("c25",   18'd4000,     16'h0250, 1'b0);
        run_vec("f77",   18'd12320,    16'h0770, 1'b0);
        run_vec("m16",   -18'sd1600,   16'h0100, 1'b1);
        run_vec("mzero", -18'sd4,      16'h0000, 1'b0);
        run_vec("r24",   18'd24,       16'h0002, 1'b0);
        run_vec("r23",   18'd23,       16'h0001, 1'b0);
        run_vec("mmin",  18'h20000,    16'h8192, 1'b1);
        run_vec("mmax",  18'h1FFFF,    16'h8192, 1'b0);

        // Ignored input during SHIFT/DONE plus 20 cycles of backpressure
        start(18'd4000);
        bus.tx10     = 18'd24;
        bus.in_valid = 1'b1;
        check("busy_in_ready", bus.in_ready, 0);
        wait_out(lat);
        check("bp_lat", lat, 16);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", bus.out_valid, 1);
            check("bp_dig",   bus.dig,       16'h0250);
            step();
        end
        check("bp_in_ready", bus.in_ready, 0);
        // Release with in_valid still high: new word waits for IDLE.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("rel_vld_drop", bus.out_valid, 0);
        check("rel_idle",     bus.in_ready,  1);
        step();
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("next_lat", lat, 16);
        check("next_dig", bus.dig, 16'h0002);
        check("next_neg", bus.neg, 0);
        bus.out_ready = 1'b1;
        step();

        // out_ready held high: out_valid lasts one cycle
        start(18'd12320);
        wait_out(lat);
        check("pulse_lat", lat, 16);
        check("pulse_dig", bus.dig, 16'h0770);
        step();
        check("pulse_drop", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Reset in the middle of SHIFT
        start(-18'sd1600);
        repeat (8) step();
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_neg",   bus.neg,       0);
        check("mid_rst_dig",   bus.dig,       0);
        check("mid_rst_blank", bus.blank,     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("mid_rst_ready", bus.in_ready, 1);
        run_vec("post_rst", 18'd23, 16'h0001, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_temp_bcd_fmt
